// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core front end.
// No logic of its own; types and a small address helper only.
// Not applicable: holds no state and applies no backpressure.
package idli_pkg;

    typedef logic [3:0]  sqi_data_t;
    typedef logic [15:0] pc_t;

    localparam logic [7:0] SQI_CMD_READ     = 8'h03;
    localparam int         SQI_ADDR_NIBBLES = 6;

    // Nibble idx (0 = most significant) of the 24b SQI byte address of word pc.
    function automatic sqi_data_t addr_nibble(input pc_t pc, input logic [2:0] idx);
        logic [23:0] addr;
        addr = {7'b0, pc, 1'b0} << {idx, 2'b00};
        return addr[23:20];
    endfunction

endpackage

// File: rtl/idli_sqi_fetch_m.sv
// Instruction fetch: SQI READ (cmd, address, dummy) then streams nibbles to the decoder.
// Latency: nibble sampled from memory appears on o_fch_enc one cycle later.
// Backpressure: stall/redirect act only between instructions; HOLD gates the SQI clock.
module idli_sqi_fetch_m
    import idli_pkg::*;
#(
    parameter pc_t RESET_PC      = 16'h0000,
    parameter int  DUMMY_NIBBLES = 2
) (
    input  logic        i_fch_gck,
    input  logic        i_fch_rst_n,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output sqi_data_t   o_sqi_data,
    output logic        o_sqi_data_oe,
    input  sqi_data_t   i_sqi_data,
    input  logic        i_fch_stall,
    input  logic        i_fch_redirect,
    input  logic [15:0] i_fch_redirect_pc,
    output sqi_data_t   o_fch_enc,
    output logic        o_fch_enc_vld,
    output logic [15:0] o_fch_pc
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_STREAM,
        ST_HOLD
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [1:0] nib;
    pc_t        fetch_pc;
    logic       pend_vld;
    pc_t        pend_pc;

    logic       redir_req;
    pc_t        redir_pc;
    logic       in_stream;
    logic       apply_redir;
    logic       capture;
    logic       wrap;

    // A redirect arriving this cycle overrides any older pending target.
    assign redir_req   = i_fch_redirect | pend_vld;
    assign redir_pc    = i_fch_redirect ? i_fch_redirect_pc : pend_pc;
    assign in_stream   = (state == ST_STREAM) || (state == ST_HOLD);
    // Outside streaming a redirect aborts at once; inside, only at an instruction boundary.
    assign apply_redir = redir_req && (!in_stream || state == ST_HOLD || nib == 2'd0);
    // At a boundary a redirect or stall suppresses the first nibble so no instruction is split.
    assign capture     = (state == ST_STREAM) &&
                         !(nib == 2'd0 && (apply_redir || i_fch_stall));
    // Memory wrap is not trusted: force a re-address after the last word.
    assign wrap        = capture && nib == 2'd3 && fetch_pc == 16'hFFFF;

    // State register
    always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
        if (!i_fch_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect always restarts through IDLE
    always_comb begin
        state_nxt = state;
        if (apply_redir) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_CMD;
                ST_CMD:    if (cnt == 3'd1) state_nxt = ST_ADDR;
                ST_ADDR:   if (cnt == 3'(SQI_ADDR_NIBBLES - 1)) state_nxt = ST_DUMMY;
                ST_DUMMY:  if (cnt == 3'(DUMMY_NIBBLES - 1)) state_nxt = ST_STREAM;
                ST_STREAM: begin
                    if (wrap) begin
                        state_nxt = ST_IDLE;
                    end else if (nib == 2'd0 && i_fch_stall) begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD:   if (!i_fch_stall) state_nxt = ST_STREAM;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // SQI bus outputs decoded from state
    always_comb begin
        o_sqi_cs_n    = 1'b1;
        o_sqi_sck_en  = 1'b0;
        o_sqi_data_oe = 1'b0;
        o_sqi_data    = '0;
        case (state)
            ST_CMD: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sck_en  = 1'b1;
                o_sqi_data_oe = 1'b1;
                o_sqi_data    = (cnt == 3'd0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
            end
            ST_ADDR: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sck_en  = 1'b1;
                o_sqi_data_oe = 1'b1;
                o_sqi_data    = addr_nibble(fetch_pc, cnt);
            end
            ST_DUMMY: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sck_en  = 1'b1;
            end
            ST_STREAM: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sck_en  = capture;
            end
            ST_HOLD: begin
                o_sqi_cs_n    = 1'b0;
            end
            default: begin
                o_sqi_cs_n    = 1'b1;
            end
        endcase
    end

    // Phase counter for CMD/ADDR/DUMMY and nibble counter for STREAM
    always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
        if (!i_fch_rst_n) begin
            cnt <= 3'd0;
            nib <= 2'd0;
        end else begin
            if (state_nxt != state) begin
                cnt <= 3'd0;
            end else if (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY) begin
                cnt <= cnt + 3'd1;
            end
            if (capture) begin
                nib <= nib + 2'd1;
            end
        end
    end

    // Fetch PC and pending redirect target
    always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
        if (!i_fch_rst_n) begin
            fetch_pc <= RESET_PC;
            pend_vld <= 1'b0;
            pend_pc  <= '0;
        end else begin
            if (apply_redir) begin
                fetch_pc <= redir_pc;
                pend_vld <= 1'b0;
            end else begin
                if (capture && nib == 2'd3) begin
                    fetch_pc <= fetch_pc + 16'd1;
                end
                if (i_fch_redirect) begin
                    pend_vld <= 1'b1;
                    pend_pc  <= i_fch_redirect_pc;
                end
            end
        end
    end

    // Registered decoder stream; PC tag follows the instruction's first nibble
    always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
        if (!i_fch_rst_n) begin
            o_fch_enc     <= '0;
            o_fch_enc_vld <= 1'b0;
            o_fch_pc      <= RESET_PC;
        end else begin
            o_fch_enc_vld <= capture;
            if (capture) begin
                o_fch_enc <= i_sqi_data;
            end
            if (capture && nib == 2'd0) begin
                o_fch_pc <= fetch_pc;
            end
        end
    end

endmodule
